// File: rtl/q_env_step.sv
// q_env_step: maze step engine resolving one (state, action) move against grid edges and a blocked-cell table.
module q_env_step #(
  parameter int ROWS   = 6,
  parameter int COLS   = 6,
  parameter int SW     = 6,
  parameter int NBLK   = 16,
  parameter int RW     = 16,
  parameter int R_GOAL = 100,
  parameter int R_STEP = -1,
  parameter int R_WALL = -10,
  parameter int CW     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [SW-1:0]           state_i,
  input  logic [1:0]              action_i,
  input  logic [SW-1:0]           target_state,
  input  logic [SW-1:0]           start_state,
  input  logic                    blk_we,
  input  logic [$clog2(NBLK)-1:0] blk_idx,
  input  logic [SW-1:0]           blk_state,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SW-1:0]           next_state,
  output logic [RW-1:0]           reward,
  output logic                    hit_goal,
  output logic                    hit_wall,
  output logic                    err,
  output logic [CW-1:0]           step_cnt,
  output logic [CW-1:0]           episode_cnt
);
  localparam int IW = $clog2(NBLK);
  localparam logic [SW-1:0] COLS_W   = SW'(COLS);
  localparam logic [SW-1:0] NCELL    = SW'(ROWS * COLS);
  localparam logic [SW-1:0] ROW_LAST = SW'(ROWS - 1);
  localparam logic [SW-1:0] COL_LAST = SW'(COLS - 1);
  localparam logic [IW-1:0] LAST     = IW'(NBLK - 1);
  localparam logic [RW-1:0] R_GOAL_W = RW'(R_GOAL);
  localparam logic [RW-1:0] R_STEP_W = RW'(R_STEP);
  localparam logic [RW-1:0] R_WALL_W = RW'(R_WALL);

  typedef enum logic [1:0] {IDLE, CALC, SCAN, RESP} st_t;
  st_t st_q, st_d;
  logic [SW-1:0] s_q, s_d, tgt_q, tgt_d, start_q, start_d, cand_q, cand_d, next_q, next_d;
  logic [1:0]    act_q, act_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          match_q, match_d, goal_q, goal_d, wall_q, wall_d, err_q, err_d, spawn_q, spawn_d;
  logic [RW-1:0] rew_q, rew_d;
  logic [CW-1:0] step_q, step_d, ep_q, ep_d;
  logic [SW-1:0] blk_q [NBLK];
  logic [SW-1:0] blk_d [NBLK];
  logic [SW-1:0] sm1, row, col, cand;
  logic          bad, edge_v, hit;

  assign sm1    = s_q - SW'(1);
  assign row    = sm1 / COLS_W;
  assign col    = sm1 % COLS_W;
  assign bad    = s_q == '0 || s_q > NCELL;
  assign edge_v = act_q == 2'd0 ? row == ROW_LAST :
                  act_q == 2'd1 ? col == COL_LAST :
                  act_q == 2'd2 ? row == '0 : col == '0;
  assign cand   = act_q == 2'd0 ? s_q + COLS_W :
                  act_q == 2'd1 ? s_q + SW'(1) :
                  act_q == 2'd2 ? s_q - COLS_W : s_q - SW'(1);
  // Empty slots hold 0, which must never be treated as a blocked cell.
  assign hit    = blk_q[idx_q] != '0 && blk_q[idx_q] == cand_q;

  assign req_ready   = st_q == IDLE && !rst;
  assign rsp_valid   = st_q == RESP;
  assign next_state  = next_q;
  assign reward      = rew_q;
  assign hit_goal    = goal_q;
  assign hit_wall    = wall_q;
  assign err         = err_q;
  assign step_cnt    = step_q;
  assign episode_cnt = ep_q;

  always_comb begin
    st_d = st_q;
    s_d = s_q;
    act_d = act_q;
    tgt_d = tgt_q;
    start_d = start_q;
    cand_d = cand_q;
    idx_d = idx_q;
    match_d = match_q;
    next_d = next_q;
    rew_d = rew_q;
    goal_d = goal_q;
    wall_d = wall_q;
    err_d = err_q;
    spawn_d = spawn_q;
    step_d = step_q;
    ep_d = ep_q;
    blk_d = blk_q;
    case (st_q)
      IDLE: begin
        if (blk_we) blk_d[blk_idx] = blk_state;
        if (req_valid) begin
          s_d = state_i;
          act_d = action_i;
          tgt_d = target_state;
          start_d = start_state;
          st_d = CALC;
        end
      end
      CALC: begin
        {goal_d, wall_d, err_d, spawn_d} = '0;
        idx_d = '0;
        match_d = 1'b0;
        next_d = s_q;
        rew_d = R_WALL_W;
        if (bad) begin
          err_d = 1'b1;
          st_d = RESP;
        end else if (s_q == tgt_q) begin
          next_d = start_q;
          rew_d = '0;
          spawn_d = 1'b1;
          st_d = RESP;
        end else if (edge_v) begin
          wall_d = 1'b1;
          st_d = RESP;
        end else begin
          cand_d = cand;
          st_d = SCAN;
        end
      end
      SCAN: begin
        match_d = match_q | hit;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          st_d = RESP;
          wall_d = match_d;
          goal_d = !match_d && cand_q == tgt_q;
          next_d = match_d ? s_q : cand_q;
          rew_d = match_d ? R_WALL_W : cand_q == tgt_q ? R_GOAL_W : R_STEP_W;
        end
      end
      default: begin
        if (rsp_ready) begin
          st_d = IDLE;
          step_d = spawn_q ? '0 : step_q + {{(CW-1){1'b0}}, ~&step_q};
          ep_d = ep_q + {{(CW-1){1'b0}}, spawn_q};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      s_q <= '0;
      act_q <= '0;
      tgt_q <= '0;
      start_q <= '0;
      cand_q <= '0;
      idx_q <= '0;
      match_q <= 1'b0;
      next_q <= '0;
      rew_q <= '0;
      goal_q <= 1'b0;
      wall_q <= 1'b0;
      err_q <= 1'b0;
      spawn_q <= 1'b0;
      step_q <= '0;
      ep_q <= '0;
      for (int i = 0; i < NBLK; i++) blk_q[i] <= '0;
    end else begin
      st_q <= st_d;
      s_q <= s_d;
      act_q <= act_d;
      tgt_q <= tgt_d;
      start_q <= start_d;
      cand_q <= cand_d;
      idx_q <= idx_d;
      match_q <= match_d;
      next_q <= next_d;
      rew_q <= rew_d;
      goal_q <= goal_d;
      wall_q <= wall_d;
      err_q <= err_d;
      spawn_q <= spawn_d;
      step_q <= step_d;
      ep_q <= ep_d;
      blk_q <= blk_d;
    end
  end
endmodule

// File: tb/tb_q_env_step.sv
// tb_q_env_step: randomized bench for q_env_step against a row/column maze model.
module tb_q_env_step;
  localparam int ROWS = 6, COLS = 6, SW = 6, NBLK = 16, RW = 16, CW = 16;

  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, blk_we = 1'b0, rsp_ready = 1'b0;
  logic req_ready, rsp_valid, hit_goal, hit_wall, err;
  logic [SW-1:0] state_i = '0, target_state = '0, start_state = '0, blk_state = '0, next_state;
  logic [1:0] action_i = '0;
  logic [3:0] blk_idx = '0;
  logic [RW-1:0] reward;
  logic [CW-1:0] step_cnt, episode_cnt;

  int checks = 0, errors = 0;
  int mtab[NBLK];
  int m_step = 0, m_ep = 0;

  always #5 clk = ~clk;

  q_env_step dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .state_i(state_i), .action_i(action_i), .target_state(target_state),
    .start_state(start_state), .blk_we(blk_we), .blk_idx(blk_idx), .blk_state(blk_state),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .next_state(next_state), .reward(reward),
    .hit_goal(hit_goal), .hit_wall(hit_wall), .err(err), .step_cnt(step_cnt),
    .episode_cnt(episode_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int s, input int a, input int tgt, input int st,
                       output int nxt, output int rew, output int g, output int w,
                       output int e, output int lat, output int sp);
    int r, c, nr, nc, cand, blocked;
    nxt = s; rew = -10; g = 0; w = 0; e = 0; lat = 2; sp = 0;
    if (s == 0 || s > ROWS * COLS) e = 1;
    else if (s == tgt) begin
      nxt = st; rew = 0; sp = 1;
    end else begin
      r = (s - 1) / COLS;
      c = (s - 1) % COLS;
      nr = r + (a == 0 ? 1 : a == 2 ? -1 : 0);
      nc = c + (a == 1 ? 1 : a == 3 ? -1 : 0);
      if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) w = 1;
      else begin
        lat = NBLK + 2;
        cand = nr * COLS + nc + 1;
        blocked = 0;
        foreach (mtab[i]) if (mtab[i] != 0 && mtab[i] == cand) blocked = 1;
        if (blocked != 0) w = 1;
        else if (cand == tgt) begin
          nxt = cand; rew = 100; g = 1;
        end else begin
          nxt = cand; rew = -1;
        end
      end
    end
  endtask

  task automatic blk_write(input int idx, input int v);
    blk_we = 1'b1; blk_idx = 4'(idx); blk_state = SW'(v);
    @(posedge clk); #1;
    blk_we = 1'b0;
    mtab[idx] = v;
  endtask

  task automatic run_req(input int s, input int a, input int tgt, input int st,
                         input int hold, input bit wr, input int wi, input int wv);
    int nxt, rew, g, w, e, lat, sp, n;
    logic [SW-1:0] h_next;
    logic [RW-1:0] h_rew;
    check("idle_ready", int'(req_ready), 1);
    if (wr) mtab[wi] = wv;
    model(s, a, tgt, st, nxt, rew, g, w, e, lat, sp);
    state_i = SW'(s); action_i = 2'(a); target_state = SW'(tgt); start_state = SW'(st);
    req_valid = 1'b1; blk_we = wr; blk_idx = 4'(wi); blk_state = SW'(wv);
    @(posedge clk); #1;
    req_valid = 1'b0; blk_we = 1'b0; n = 1;
    while (!rsp_valid && n < NBLK + 10) begin
      check("busy_ready", int'(req_ready), 0);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, lat);
    check("next", int'(next_state), nxt);
    check("reward", int'($signed(reward)), rew);
    check("hit_goal", int'(hit_goal), g);
    check("hit_wall", int'(hit_wall), w);
    check("err", int'(err), e);
    h_next = next_state; h_rew = reward;
    for (int i = 0; i < hold; i++) begin
      blk_we = (i == 0); blk_idx = 4'd0; blk_state = SW'(2);
      @(posedge clk); #1;
      blk_we = 1'b0;
      check("hold_valid", int'(rsp_valid), 1);
      check("hold_ready", int'(req_ready), 0);
      check("hold_next", int'(next_state), int'(h_next));
      check("hold_reward", int'(reward), int'(h_rew));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (sp != 0) begin
      m_ep = (m_ep + 1) & 32'hffff; m_step = 0;
    end else if (m_step < 65535) m_step++;
    check("step_cnt", int'(step_cnt), m_step);
    check("episode_cnt", int'(episode_cnt), m_ep);
    check("post_valid", int'(rsp_valid), 0);
    check("post_ready", int'(req_ready), 1);
  endtask

  initial begin
    int s, a, tgt, st;
    foreach (mtab[i]) mtab[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(req_ready), 0);
    check("rst_valid", int'(rsp_valid), 0);
    check("rst_next", int'(next_state), 0);
    check("rst_reward", int'(reward), 0);
    check("rst_flags", int'({hit_goal, hit_wall, err}), 0);
    check("rst_step", int'(step_cnt), 0);
    check("rst_ep", int'(episode_cnt), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", int'(req_ready), 1);

    run_req(1, 1, 36, 1, 0, 0, 0, 0);
    run_req(6, 1, 36, 1, 0, 0, 0, 0);
    run_req(31, 0, 36, 1, 0, 0, 0, 0);
    blk_write(15, 8);
    run_req(2, 0, 36, 1, 0, 0, 0, 0);
    blk_write(15, 0);
    run_req(2, 0, 36, 1, 0, 0, 0, 0);
    run_req(30, 0, 36, 1, 0, 0, 0, 0);
    run_req(36, 0, 36, 1, 0, 0, 0, 0);
    run_req(1, 1, 36, 1, 5, 0, 0, 0);
    run_req(1, 1, 36, 1, 0, 0, 0, 0);
    run_req(3, 1, 36, 1, 0, 1, 7, 4);
    run_req(37, 2, 36, 1, 0, 0, 0, 0);

    state_i = SW'(1); action_i = 2'd1; target_state = SW'(36); start_state = SW'(1);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", int'(rsp_valid), 0);
    check("abort_ready", int'(req_ready), 0);
    check("abort_step", int'(step_cnt), 0);
    check("abort_ep", int'(episode_cnt), 0);
    rst = 1'b0;
    m_step = 0; m_ep = 0;
    foreach (mtab[i]) mtab[i] = 0;
    @(posedge clk); #1;
    check("abort_ready_after", int'(req_ready), 1);
    repeat (NBLK + 4) @(posedge clk);
    #1;
    check("abort_no_rsp", int'(rsp_valid), 0);
    run_req(3, 1, 36, 1, 0, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      s = $urandom_range(0, 40);
      a = $urandom_range(0, 3);
      tgt = $urandom_range(1, 36);
      st = $urandom_range(1, 36);
      if ($urandom_range(0, 5) == 0 && s >= 1 && s <= 36) tgt = s;
      if ($urandom_range(0, 2) == 0) blk_write($urandom_range(0, NBLK - 1), $urandom_range(0, 36));
      run_req(s, a, tgt, st, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
              $urandom_range(0, NBLK - 1), $urandom_range(0, 36));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
